// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file for the 5-stage MIPS pipeline.
// The two ID read ports are combinational with write-first bypass; commit_count tracks committed writes.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wb_mem_data,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [1:0]        wb_control,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [31:0]       commit_count
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam int unsigned CNT_W    = 32;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // MemtoReg picks the load data; the value is driven even when RegWrite is low.
    assign wb_data = wb_control[0] ? wb_mem_data : wb_alu_result;
    assign wb_we   = rst_n & wb_control[1] & (wb_rd != '0);

    // Index 0 reads as zero and never bypasses; a pending write to the same index wins.
    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wb_we && (rs_addr == wb_rd)) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wb_we && (rt_addr == wb_rd)) begin
            rt_data = wb_data;
        end
    end

    // Reset clears the array and discards any write-back presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
            commit_count <= '0;
        end else if (wb_we) begin
            regs[wb_rd]  <= wb_data;
            commit_count <= commit_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, select/commit, bypass, r0, RegWrite low, counter wrap.
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_alu_result;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_control;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [31:0] commit_count;

    int checks   = 0;
    int failures = 0;

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_mem_data  (wb_mem_data),
        .wb_alu_result(wb_alu_result),
        .wb_rd        (wb_rd),
        .wb_control   (wb_control),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .wb_data      (wb_data),
        .wb_we        (wb_we),
        .commit_count (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a MEM/WB bundle plus read indices, then let combinational paths settle.
    task automatic drive(input logic [1:0] ctrl, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [4:0] ra, input logic [4:0] rb);
        wb_control    = ctrl;
        wb_rd         = rd;
        wb_alu_result = alu;
        wb_mem_data   = mem;
        rs_addr       = ra;
        rt_addr       = rb;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        step();
        step();
        rst_n = 1'b1;
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd5, 5'd7);
        check("reset_count", commit_count, 32'h0);
        check("reset_rs5", rs_data, 32'h0);

        // Preload r5, then reset with a write pending to r7
        drive(2'b10, 5'd5, 32'h1234, 32'h0, 5'd5, 5'd7);
        step();
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd5, 5'd7);
        check("preload_r5", rs_data, 32'h1234);
        check("preload_count", commit_count, 32'h1);
        rst_n = 1'b0;
        drive(2'b10, 5'd7, 32'hAAAA, 32'h0, 5'd5, 5'd7);
        check("rst_we_low", 32'(wb_we), 32'h0);
        check("rst_wbdata", wb_data, 32'hAAAA);
        check("rst_no_bypass", rt_data, 32'h0);
        step();
        rst_n = 1'b1;
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd5, 5'd7);
        check("post_rst_r5", rs_data, 32'h0);
        check("post_rst_r7", rt_data, 32'h0);
        check("post_rst_count", commit_count, 32'h0);

        // Write-back select and commit
        drive(2'b10, 5'd3, 32'hDEAD_BEEF, 32'h1111, 5'd0, 5'd0);
        check("sel_alu", wb_data, 32'hDEAD_BEEF);
        check("sel_we", 32'(wb_we), 32'h1);
        step();
        drive(2'b11, 5'd4, 32'hDEAD_BEEF, 32'h1111, 5'd3, 5'd0);
        check("commit_r3", rs_data, 32'hDEAD_BEEF);
        check("sel_mem", wb_data, 32'h1111);
        step();
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd3, 5'd4);
        check("commit_r4", rt_data, 32'h1111);
        check("commit_count2", commit_count, 32'h2);

        // Bypass on both ports
        drive(2'b10, 5'd9, 32'h10, 32'h0, 5'd9, 5'd9);
        step();
        drive(2'b10, 5'd9, 32'h55, 32'h0, 5'd9, 5'd9);
        check("bypass_rs", rs_data, 32'h55);
        check("bypass_rt", rt_data, 32'h55);
        step();
        drive(2'b10, 5'd9, 32'h66, 32'h0, 5'd9, 5'd3);
        check("r9_committed", rs_data, 32'h66);
        check("rt_no_bypass", rt_data, 32'hDEAD_BEEF);
        step();
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0);
        check("r9_after", rs_data, 32'h66);
        check("count5", commit_count, 32'h5);

        // Register 0 is never written
        drive(2'b10, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
        check("r0_we", 32'(wb_we), 32'h0);
        check("r0_same", rs_data, 32'h0);
        step();
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        check("r0_next", rt_data, 32'h0);
        check("r0_count", commit_count, 32'h5);

        // RegWrite low: value selected but not committed or bypassed
        drive(2'b01, 5'd6, 32'h0, 32'h77, 5'd6, 5'd0);
        check("nowr_we", 32'(wb_we), 32'h0);
        check("nowr_wbdata", wb_data, 32'h77);
        check("nowr_nobypass", rs_data, 32'h0);
        step();
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd6, 5'd0);
        check("nowr_r6", rs_data, 32'h0);
        check("nowr_count", commit_count, 32'h5);

        // Counter wrap
        force dut.commit_count = 32'hFFFF_FFFF;
        #1;
        release dut.commit_count;
        drive(2'b10, 5'd1, 32'hCAFE, 32'h0, 5'd1, 5'd0);
        step();
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd1, 5'd0);
        check("wrap_count", commit_count, 32'h0);
        check("wrap_r1", rs_data, 32'hCAFE);
        drive(2'b11, 5'd2, 32'h0, 32'hBEEF, 5'd0, 5'd2);
        step();
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd2);
        check("wrap_next", commit_count, 32'h1);
        check("r2_mem", rt_data, 32'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
